// File: rtl/neuron_operand_loader_if.sv
// Serial operand stream feeding neuron_operand_loader.
// One (input, weight) pair per beat; bias travels with the final beat.
interface neuron_operand_loader_if #(
    parameter int IW = 8,
    parameter int WW = 16
) ();
    logic          s_clear;
    logic          s_valid;
    logic          s_ready;
    logic [IW-1:0] s_in;
    logic [WW-1:0] s_weight;
    logic [IW-1:0] s_bias;

    modport master (
        output s_clear, s_valid, s_in, s_weight, s_bias,
        input  s_ready
    );

    modport slave (
        input  s_clear, s_valid, s_in, s_weight, s_bias,
        output s_ready
    );
endinterface

// File: rtl/neuron_operand_loader.sv
// Serial-to-parallel operand loader in front of single_neuron.
// Optional LOADER_WEIGHT_KEEP_EN adds w_keep to reuse the held weights.
module neuron_operand_loader #(
    parameter int N  = 2,
    parameter int QM = 3,
    parameter int QN = 5,
    parameter int WM = 6,
    parameter int WN = 10
) (
    input  logic                          clk,
    input  logic                          nrst,
    neuron_operand_loader_if.slave        s,
`ifdef LOADER_WEIGHT_KEEP_EN
    input  logic                          w_keep,
`endif
    output logic [N-1:0][QM+QN-1:0]       inputs,
    output logic [N-1:0][WM+WN-1:0]       weights,
    output logic [QM+QN-1:0]              bias,
    output logic                          vec_valid,
    input  logic                          vec_ready,
    output logic [$clog2(N):0]            beat_idx
);
    localparam int BW = $clog2(N) + 1;

    typedef enum logic {LOAD, FULL} state_t;

    state_t        state, state_nx;
    logic [BW-1:0] idx_nx;
    logic          wr;
    logic          last;
    logic          keep_eff;
    logic          keep_q, keep_nx;

    assign s.s_ready = (state == LOAD);
    assign vec_valid = (state == FULL);

    always_comb begin
        state_nx = state;
        idx_nx   = beat_idx;
        wr       = 1'b0;
        last     = 1'b0;
        unique case (state)
            LOAD: begin
                if (s.s_valid) begin
                    wr = 1'b1;
                    if (beat_idx == BW'(N-1)) begin
                        last     = 1'b1;
                        idx_nx   = '0;
                        state_nx = FULL;
                    end else begin
                        idx_nx = beat_idx + 1'b1;
                    end
                end
            end
            FULL: begin
                if (vec_ready)
                    state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
        // Flush wins over both a pending beat and a consumer accept
        if (s.s_clear) begin
            state_nx = LOAD;
            idx_nx   = '0;
            wr       = 1'b0;
            last     = 1'b0;
        end
    end

`ifdef LOADER_WEIGHT_KEEP_EN
    // Beat 0 decides for the frame; later beats follow the flopped flag
    always_comb begin
        keep_eff = (beat_idx == '0) ? w_keep : keep_q;
        keep_nx  = keep_q;
        if (wr)
            keep_nx = last ? 1'b0 : keep_eff;
        if (s.s_clear)
            keep_nx = 1'b0;
    end
`else
    assign keep_eff = 1'b0;
    assign keep_nx  = 1'b0;
`endif

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state    <= LOAD;
            beat_idx <= '0;
            keep_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            beat_idx <= idx_nx;
            keep_q   <= keep_nx;
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            inputs  <= '0;
            weights <= '0;
            bias    <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr && beat_idx == BW'(i)) begin
                    inputs[i] <= s.s_in;
                    if (!keep_eff)
                        weights[i] <= s.s_weight;
                end
            end
            if (last)
                bias <= s.s_bias;
        end
    end
endmodule
